// File: rtl/calc_ctrl.sv
// calc_ctrl: button conditioning plus the A/B/result sequencer for the 4-bit calculator.
// calc_btn turns a raw button into a one-cycle press pulse: synchronizer, debouncer, edge detect.
module calc_btn #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   db_q;
    logic                   db_d_q;
    logic                   pulse_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign pulse  = pulse_q;

    // Synchronize the raw button, debounce the synced level, and register its rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            db_d_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            if (synced == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= synced;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            db_d_q  <= db_q;
            pulse_q <= db_q & ~db_d_q;
        end
    end

endmodule

module calc_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       op_sw,
    input  logic       interp_sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] x,
    output logic       interp,
    output logic       ovf,
    output logic [2:0] state_led
);

    typedef enum logic [2:0] {
        ENTER_A  = 3'b001,
        ENTER_B  = 3'b010,
        SHOW_RES = 3'b100
    } state_t;

    state_t     state_q, state_n;
    logic [3:0] a_q, a_n, b_q, b_n, r_q, r_n;
    logic       ovf_q, ovf_n, int_q, int_n;
    logic       enter_p, clear_p;
    logic [4:0] add_full;
    logic [3:0] res;
    logic       ovf_calc;

    calc_btn #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_enter (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_enter),
        .pulse   (enter_p)
    );

    calc_btn #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_clear),
        .pulse   (clear_p)
    );

    // Result and overflow for the current A and the live switches (B being entered).
    always_comb begin
        add_full = {1'b0, a_q} + {1'b0, sw};
        res      = '0;
        ovf_calc = 1'b0;
        if (op_sw) begin
            res = a_q - sw;
            if (interp_sw) ovf_calc = (a_q[3] != sw[3]) && (res[3] != a_q[3]);
            else           ovf_calc = (a_q < sw);
        end else begin
            res = add_full[3:0];
            if (interp_sw) ovf_calc = (a_q[3] == sw[3]) && (res[3] != a_q[3]);
            else           ovf_calc = add_full[4];
        end
    end

    // Next-state and register-load decisions; clear takes priority over enter.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        r_n     = r_q;
        ovf_n   = ovf_q;
        int_n   = int_q;
        if (clear_p) begin
            state_n = ENTER_A;
            a_n     = '0;
            b_n     = '0;
            r_n     = '0;
            ovf_n   = 1'b0;
            int_n   = 1'b0;
        end else if (enter_p) begin
            case (state_q)
                ENTER_A: begin
                    a_n     = sw;
                    state_n = ENTER_B;
                end
                ENTER_B: begin
                    b_n     = sw;
                    r_n     = res;
                    ovf_n   = ovf_calc;
                    int_n   = interp_sw;
                    state_n = SHOW_RES;
                end
                SHOW_RES: state_n = ENTER_A;
                default:  state_n = ENTER_A;
            endcase
        end
    end

    // State and operand/result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            r_q     <= r_n;
            ovf_q   <= ovf_n;
            int_q   <= int_n;
        end
    end

    // Display outputs: live switches while entering, registered result while showing.
    always_comb begin
        state_led = state_q;
        if (state_q == SHOW_RES) begin
            x      = r_q;
            interp = int_q;
            ovf    = ovf_q;
        end else begin
            x      = sw;
            interp = interp_sw;
            ovf    = 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed and randomized checks of calc_ctrl against an arithmetic model.
module tb_calc_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;
    localparam int SETTLE      = SYNC_STAGES + DB_CYCLES + 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sw;
    logic       op_sw, interp_sw, btn_enter, btn_clear;
    logic [3:0] x;
    logic       interp, ovf;
    logic [2:0] state_led;

    int total = 0;
    int bad   = 0;

    // Model: stage 0/1/2 = entering A / entering B / showing result.
    int m_stage, m_a, m_b, m_r, m_ovf, m_int;

    calc_ctrl #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw        (sw),
        .op_sw     (op_sw),
        .interp_sw (interp_sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .x         (x),
        .interp    (interp),
        .ovf       (ovf),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_stage = 0; m_a = 0; m_b = 0; m_r = 0; m_ovf = 0; m_int = 0;
    endtask

    task automatic model_enter();
        int full, sa, sb, sf;
        case (m_stage)
            0: begin m_a = int'(sw); m_stage = 1; end
            1: begin
                m_b   = int'(sw);
                full  = op_sw ? m_a - m_b : m_a + m_b;
                m_r   = full & 15;
                sa    = (m_a >= 8) ? m_a - 16 : m_a;
                sb    = (m_b >= 8) ? m_b - 16 : m_b;
                sf    = op_sw ? sa - sb : sa + sb;
                m_int = int'(interp_sw);
                if (interp_sw) m_ovf = (sf < -8 || sf > 7) ? 1 : 0;
                else           m_ovf = (full < 0 || full > 15) ? 1 : 0;
                m_stage = 2;
            end
            default: m_stage = 0;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".led"}, int'(state_led), 1 << m_stage);
        chk({tag, ".x"}, int'(x), (m_stage == 2) ? m_r : int'(sw));
        chk({tag, ".interp"}, int'(interp), (m_stage == 2) ? m_int : int'(interp_sw));
        chk({tag, ".ovf"}, int'(ovf), (m_stage == 2) ? m_ovf : 0);
    endtask

    // Press a button for `hold` cycles, release, and wait for it to settle.
    task automatic press(input bit is_clear, input int hold);
        @(negedge clk);
        if (is_clear) btn_clear = 1'b1; else btn_enter = 1'b1;
        repeat (hold) @(negedge clk);
        btn_clear = 1'b0;
        btn_enter = 1'b0;
        repeat (SETTLE) @(negedge clk);
        if (is_clear) model_clear(); else model_enter();
    endtask

    task automatic do_op(input string tag, input int a, input int b, input bit op, input bit ip);
        sw = 4'(a); op_sw = op; interp_sw = ip;
        if (m_stage != 0) begin
            press(1'b1, 10);
        end
        press(1'b0, 10);
        check_outputs({tag, ".b"});
        sw = 4'(b);
        press(1'b0, 10);
        check_outputs({tag, ".res"});
    endtask

    initial begin
        int lat;
        logic [2:0] led0;
        reset_n = 1'b0; sw = '0; op_sw = 0; interp_sw = 0; btn_enter = 0; btn_clear = 0;
        model_clear();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of ENTER_B discards A.
        sw = 4'd3;
        press(1'b0, 10);
        check_outputs("rst_pre");
        #2 reset_n = 1'b0;
        #1 chk("rst_async.led", int'(state_led), 1);
        model_clear();
        @(negedge clk);
        sw = 4'd5;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("rst_post");
        press(1'b0, 10);
        sw = 4'd2;
        press(1'b0, 10);
        check_outputs("rst_op");
        chk("rst_op.sum", int'(x), 7);

        // Directed arithmetic cases.
        do_op("uadd1", 7, 5, 0, 0);
        chk("uadd1.val", int'(x), 12);
        do_op("uadd2", 12, 5, 0, 0);
        chk("uadd2.ovf", int'(ovf), 1);
        do_op("sadd", 7, 1, 0, 1);
        chk("sadd.val", int'(x), 8);
        sw = 4'd9; interp_sw = 1'b0; op_sw = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs("hold_res");
        chk("hold_res.x", int'(x), 8);
        do_op("usub", 2, 3, 1, 0);
        chk("usub.ovf", int'(ovf), 1);
        do_op("ssub", 2, 3, 1, 1);
        chk("ssub.ovf", int'(ovf), 0);
        do_op("ssub2", 8, 1, 1, 1);
        chk("ssub2.val", int'(x), 7);

        // Clear from SHOW_RES.
        press(1'b1, 10);
        check_outputs("clr_show");

        // Short glitch on enter: no transition.
        led0 = state_led;
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (DB_CYCLES - 1) @(negedge clk);
        btn_enter = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch.led", int'(state_led), int'(led0));

        // Held press: latency and exactly one transition.
        sw = 4'd6;
        led0 = state_led;
        lat = 0;
        @(negedge clk);
        btn_enter = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (state_led != led0) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, SYNC_STAGES + DB_CYCLES + 2);
        repeat (40 - ((lat > 0) ? lat : 30)) @(negedge clk);
        btn_enter = 1'b0;
        repeat (SETTLE) @(negedge clk);
        model_enter();
        check_outputs("held40");

        // Enter and clear together: clear wins.
        press(1'b0, 10);
        check_outputs("pre_both");
        @(negedge clk);
        btn_enter = 1'b1; btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (SETTLE) @(negedge clk);
        model_clear();
        check_outputs("both");

        // Randomized operations with occasional aborts.
        for (int n = 0; n < 24; n++) begin
            int a, b;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            sw = 4'(a); op_sw = 1'($urandom); interp_sw = 1'($urandom);
            press(1'b0, int'($urandom_range(8, 14)));
            check_outputs("rnd.a");
            sw = 4'(b); op_sw = 1'($urandom); interp_sw = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                press(1'b1, 9);
                check_outputs("rnd.clr");
            end else begin
                press(1'b0, int'($urandom_range(8, 14)));
                check_outputs("rnd.res");
                sw = 4'($urandom); interp_sw = 1'($urandom);
                press(1'b0, 9);
                check_outputs("rnd.back");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
